vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60 Hz VGA timing from the 50 MHz board clock.
//  Produces pixel coordinates x/y for the downstream pixel printers (board lines, marks),
//  plus sync/blank/clock strobes for the video DAC.
//  Printers decode x/y combinationally. Their RGB is valid only while active=1.
// PARAMETERS
//  CLK_DIV   2    clk cycles per pixel; even, >=2
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
// PORTS
//  clk          in   1   system clock, 50 MHz
//  rst_n        in   1   asynchronous active-low reset
//  x            out  10  current pixel column, 0..H_TOTAL-1 (799)
//  y            out  10  current line, 0..V_TOTAL-1 (524)
//  active       out  1   1 when x<H_ACTIVE and y<V_ACTIVE (drives DAC blank_n)
//  hsync_n      out  1   horizontal sync, active low
//  vsync_n      out  1   vertical sync, active low
//  vga_clk      out  1   pixel clock to DAC; rising edge mid-pixel
//  pix_en       out  1   1-clk strobe in the last clk of each pixel period
//  frame_start  out  1   1-clk pulse in the first clk of pixel (0,0)
// BEHAVIOUR
//  - H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 and 525.
//  - Reset, asynchronous on rst_n=0:
//    div_cnt=0, x=0, y=0, active=1, hsync_n=1, vsync_n=1,
//    vga_clk=0, pix_en=0, frame_start=1.
//    Outputs hold these values while rst_n=0.
//  - Release: counting starts on the first clk rising edge with rst_n=1.
//    No synchroniser is required; rst_n is synchronised at top level.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
//    pix_en=1 exactly when div_cnt==CLK_DIV-1.
//  - vga_clk = (div_cnt >= CLK_DIV/2). With CLK_DIV=2 this is a 25 MHz square wave.
//  - Horizontal counter: x advances only on a clk edge where pix_en=1.
//    x wraps from H_TOTAL-1 to 0.
//  - Vertical counter: y advances only when x wraps.
//    y wraps from V_TOTAL-1 to 0 in the same edge as x wraps.
//  - Each pixel (x,y) is held for exactly CLK_DIV clk cycles.
//  - active, hsync_n and vsync_n are registers loaded from the next-state x/y.
//    They are therefore aligned with x/y in the same cycle: zero skew, no combinational path.
//  - hsync_n=0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 default).
//  - vsync_n=0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491 default).
//    vsync_n changes only together with a y change.
//  - frame_start=1 for exactly 1 clk: the first clk in which x=0 and y=0.
//    This includes the first clk after reset release.
//  - Frame period: H_TOTAL*V_TOTAL*CLK_DIV clk = 840000 (59.52 Hz).
//  - No other inputs exist. Timing is free-running and never stalls.
//  - Reset asserted mid-line or mid-frame returns all outputs to reset values immediately.
//    No partial frame is preserved.
// TESTING
//  1. Reset: hold rst_n=0 for 5 clk.
//     -> x=0, y=0, active=1, hsync_n=1, vsync_n=1, vga_clk=0, pix_en=0.
//  2. Pixel pacing: after release, x steps 0,1,2 every 2 clk.
//     -> pix_en high every 2nd clk; vga_clk toggles every clk.
//  3. Line: one full line.
//     -> hsync_n falls when x becomes 656, rises when x becomes 752 (192 clk low).
//     -> active falls when x becomes 640.
//     -> x wraps 799->0 with y 0->1.
//  4. Frame: one full frame.
//     -> vsync_n low exactly for y=490..491 (1600 pixels, 3200 clk).
//     -> active-high clk count = 614400.
//     -> frame_start pulses repeat every 840000 clk.
//  5. Mid-operation reset: assert rst_n at x=700, y=300 (asynchronous, between edges).
//     -> outputs at reset values without waiting for a clk edge.
//     -> after release, x=0, y=0 and frame_start=1.
//  6. Parameter override CLK_DIV=4, H_*={8,2,2,2}, V_*={4,1,1,1}.
//     -> H_TOTAL=14, V_TOTAL=7.
//     -> hsync_n low for x=10..11; frame period = 392 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing, divided from the system clock.
// Ports: clk, rst_n (async, active low) in; x, y, active, hsync_n, vsync_n, vga_clk, pix_en, frame_start out.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       vga_clk,
  output logic       pix_en,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] X_HSB  = 10'(HS_BEG);
  localparam logic [9:0] X_HSE  = 10'(HS_END);
  localparam logic [9:0] Y_VSB  = 10'(VS_BEG);
  localparam logic [9:0] Y_VSE  = 10'(VS_END);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             active_q, active_d;
  logic             hsync_n_q, hsync_n_d;
  logic             vsync_n_q, vsync_n_d;
  logic             vga_clk_q, vga_clk_d;
  logic             pix_en_q, pix_en_d;
  logic             frame_start_q, frame_start_d;
  logic             pix_step;

  always_comb begin
    pix_step = (div_q == DIV_LAST);

    div_d = div_q + DIV_W'(1);
    if (pix_step) begin
      div_d = '0;
    end

    x_d = x_q;
    y_d = y_q;
    if (pix_step) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decoded from next-state counters so the registered
    // strobes line up with x/y in the same cycle.
    active_d  = (x_d < X_ACT) && (y_d < Y_ACT);
    hsync_n_d = !((x_d >= X_HSB) && (x_d < X_HSE));
    vsync_n_d = !((y_d >= Y_VSB) && (y_d < Y_VSE));
    vga_clk_d = (div_d >= DIV_HALF);
    pix_en_d  = (div_d == DIV_LAST);
    // Only the first divider phase of pixel (0,0) marks the frame.
    frame_start_d = (div_d == '0) && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b1;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      vga_clk_q     <= 1'b0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      vga_clk_q     <= vga_clk_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign vga_clk     = vga_clk_q;
  assign pix_en      = pix_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default and a small-parameter instance against
// an elapsed-time arithmetic model, with directed and randomized resets.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic act;
    logic hs;
    logic vs;
    logic vc;
    logic pe;
    logic fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0] x0, y0, x1, y1;
  logic act0, hs0, vs0, vc0, pe0, fs0;
  logic act1, hs1, vs1, vc1, pe1, fs1;

  int checks = 0;
  int errors = 0;
  int t = 0;

  int hs_low, hs_fall_x, hs_rise_x, act_fall_x;
  int vs_low, act_cnt, fs_t0, fs_t1, hx_min, hx_max;
  logic prev_hs, prev_act;

  always #10 clk = ~clk;

  vga_timing_gen u0 (
    .clk(clk), .rst_n(rst_n), .x(x0), .y(y0),
    .active(act0), .hsync_n(hs0), .vsync_n(vs0),
    .vga_clk(vc0), .pix_en(pe0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(4),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1),
    .active(act1), .hsync_n(hs1), .vsync_n(vs1),
    .vga_clk(vc1), .pix_en(pe1), .frame_start(fs1)
  );

  // Outputs as a function of clk edges elapsed since reset release.
  function automatic exp_t model(int tt, int cd,
                                 int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb);
    exp_t m;
    int ht, vt, p, dv, xx, yy;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = tt / cd;
    dv = tt % cd;
    xx = p % ht;
    yy = (p / ht) % vt;
    m.x   = 10'(xx);
    m.y   = 10'(yy);
    m.act = (xx < ha) && (yy < va);
    m.hs  = !((xx >= ha + hf) && (xx < ha + hf + hsw));
    m.vs  = !((yy >= va + vf) && (yy < va + vf + vsw));
    m.vc  = (dv >= cd / 2);
    m.pe  = (dv == cd - 1);
    m.fs  = (tt % (cd * ht * vt)) == 0;
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t e0, e1;
    e0 = model(t, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    e1 = model(t, 4, 8, 2, 2, 2, 4, 1, 1, 1);
    chk("d0.x", 32'(x0), 32'(e0.x));
    chk("d0.y", 32'(y0), 32'(e0.y));
    chk("d0.active", 32'(act0), 32'(e0.act));
    chk("d0.hsync_n", 32'(hs0), 32'(e0.hs));
    chk("d0.vsync_n", 32'(vs0), 32'(e0.vs));
    chk("d0.vga_clk", 32'(vc0), 32'(e0.vc));
    chk("d0.pix_en", 32'(pe0), 32'(e0.pe));
    chk("d0.frame_start", 32'(fs0), 32'(e0.fs));
    chk("d1.x", 32'(x1), 32'(e1.x));
    chk("d1.y", 32'(y1), 32'(e1.y));
    chk("d1.active", 32'(act1), 32'(e1.act));
    chk("d1.hsync_n", 32'(hs1), 32'(e1.hs));
    chk("d1.vsync_n", 32'(vs1), 32'(e1.vs));
    chk("d1.vga_clk", 32'(vc1), 32'(e1.vc));
    chk("d1.pix_en", 32'(pe1), 32'(e1.pe));
    chk("d1.frame_start", 32'(fs1), 32'(e1.fs));
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    #1;
    check_all();
  endtask

  // Called 1 time unit after a rising edge: asserts reset between edges
  // and checks that outputs return without any clock edge.
  task automatic do_reset(int hold);
    #($urandom_range(1, 7));
    rst_n = 1'b0;
    #1;
    t = 0;
    check_all();
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    // Reset held for 5 clk.
    repeat (5) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();

    // One full default line, with edge positions recorded.
    hs_low = 0;
    hs_fall_x = -1;
    hs_rise_x = -1;
    act_fall_x = -1;
    prev_hs = 1'b1;
    prev_act = 1'b1;
    repeat (1600) begin
      tick();
      if (!hs0) hs_low++;
      if (prev_hs && !hs0) hs_fall_x = int'(x0);
      if (!prev_hs && hs0) hs_rise_x = int'(x0);
      if (prev_act && !act0 && act_fall_x < 0) act_fall_x = int'(x0);
      prev_hs = hs0;
      prev_act = act0;
    end
    chk("line.hsync_low_clks", 32'(hs_low), 32'd192);
    chk("line.hsync_fall_x", 32'(hs_fall_x), 32'd656);
    chk("line.hsync_rise_x", 32'(hs_rise_x), 32'd752);
    chk("line.active_fall_x", 32'(act_fall_x), 32'd640);
    chk("line.wrap_x", 32'(x0), 32'd0);
    chk("line.wrap_y", 32'(y0), 32'd1);

    // Advance to x=700 and reset mid-line.
    repeat (1400) tick();
    chk("mid.x_before", 32'(x0), 32'd700);
    do_reset(3);

    // Two small frames on the overridden instance.
    vs_low = 0;
    act_cnt = 0;
    fs_t0 = -1;
    fs_t1 = -1;
    hx_min = 1000;
    hx_max = -1;
    repeat (784) begin
      tick();
      if (t <= 392) begin
        if (!vs1) vs_low++;
        if (act1) act_cnt++;
      end
      if (!hs1) begin
        if (int'(x1) < hx_min) hx_min = int'(x1);
        if (int'(x1) > hx_max) hx_max = int'(x1);
      end
      if (fs1) begin
        if (fs_t0 < 0) fs_t0 = t;
        else if (fs_t1 < 0) fs_t1 = t;
      end
    end
    chk("small.vsync_low_clks", 32'(vs_low), 32'd56);
    chk("small.active_clks", 32'(act_cnt), 32'd128);
    chk("small.first_frame_t", 32'(fs_t0), 32'd392);
    chk("small.frame_period", 32'(fs_t1 - fs_t0), 32'd392);
    chk("small.hsync_x_min", 32'(hx_min), 32'd10);
    chk("small.hsync_x_max", 32'(hx_max), 32'd11);

    // Random run lengths interrupted by asynchronous resets.
    repeat (8) begin
      repeat ($urandom_range(1, 3000)) tick();
      do_reset($urandom_range(0, 4));
    end
    repeat (50) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
